maxpool_window_sched: RTL
=========================

Name: maxpool_window_sched

Overview:
- Frame-level controller for the 3x3 max-pooling datapath (line buffers plus 3-stage max tree).
- Tracks the row/column position of the incoming pixel stream over a WIDTH x HEIGHT map and drives the line-buffer write/shift enables.
- Fires the max-tree stage enables only for window positions on the STRIDE grid.
- Brackets each frame with a start/busy/done handshake.

Parameters:
- WIDTH, 5, feature-map columns (>=3)
- HEIGHT, 5, feature-map rows (>=3)
- STRIDE, 2, pooling stride in both axes (1..3)
- CNT_W, 8, width of row/col counters (2^CNT_W > max(WIDTH,HEIGHT))

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  frame start pulse, honoured only in IDLE
- valid_in  in  1  pixel valid from upstream stream
- line_wr_en  out  1  write accepted pixel into line buffer
- line_shift  out  1  rotate line buffers at end of each row
- valid_in_max  out  3  max-tree stage enables: [0] row max, [1] column max, [2] final register
- valid_out  out  1  pooled result valid
- out_row  out  CNT_W  output-map row of current valid_out
- out_col  out  CNT_W  output-map column of current valid_out
- busy  out  1  high from start accept until frame_done
- frame_done  out  1  one-cycle pulse after last result leaves pipeline

Behaviour:
- Reset: state=IDLE, all counters 0, every output 0. Reset mid-frame aborts immediately, with no frame_done.
- States and transitions:
  - IDLE: on start -> FILL, busy=1.
  - FILL: image rows 0..1. After the accepted pixel (row 1, col WIDTH-1) -> RUN.
  - RUN: row >= 2. After the accepted pixel (HEIGHT-1, WIDTH-1) -> DRAIN.
  - DRAIN: exactly 4 cycles, counted by a 2-bit counter, then -> DONE.
  - DONE: frame_done=1 and busy=0 for 1 cycle, then -> IDLE.
- Pixel acceptance:
  - A pixel is accepted when valid_in=1 in FILL or RUN. valid_in is ignored in IDLE, DRAIN and DONE.
  - valid_in may drop at any cycle (bubbles). Counters hold during bubbles.
- line_wr_en is combinational: equals accept.
- line_shift is combinational: equals accept AND col==WIDTH-1.
- Counters:
  - col wraps WIDTH-1 -> 0 and increments row.
  - row does not wrap; the state change handles frame end.
- Stride phase counters:
  - cph advances on each accepted pixel with col>=2, resets to 0 at row end.
  - rph advances at each row end with row>=2.
  - Both wrap STRIDE-1 -> 0. No divide/modulo hardware.
- Window hit: accept AND row>=2 AND col>=2 AND cph==0 AND rph==0.
- Pipeline timing: hit at cycle t gives valid_in_max[0] at t+1, [1] at t+2, [2] at t+3, valid_out at t+4.
  - Fixed latency of 4; enables follow bubbles exactly.
- out_row/out_col:
  - Output counters increment on valid_out; out_col wraps at OW-1 and increments out_row.
  - OW = (WIDTH-3)/STRIDE+1, OH = (HEIGHT-3)/STRIDE+1.
  - Both cleared at start. They hold the index of the valid_out in the same cycle.
- Results per frame: exactly OW*OH valid_out pulses. 5x5 with STRIDE=2 gives 4; STRIDE=1 gives 9.
- Simultaneous events:
  - start while busy: ignored.
  - start in the DONE cycle: ignored; it must be reasserted in IDLE.
  - The last pixel's hit is still issued on the FILL/RUN -> DRAIN transition cycle.
- frame_done is asserted in the cycle after the final valid_out.

Optional Feature:
- Macro: MAXPOOL_SCHED_ERR_EN.
- Defined:
  - Adds output proto_err (1 bit), a sticky flag set when valid_in=1 in DRAIN or DONE (pixel dropped), or when start=1 while busy.
  - Cleared only by rst or by an accepted start.
- Undefined:
  - No proto_err port.
  - Such events are silently ignored; all other behaviour is identical.

Test Plan:
- Reset, then start, then 25 back-to-back pixels (5x5, STRIDE=2) -> hits at pixel indices 12,14,22,24.
  - valid_out at 4 cycles after each hit, with (out_row,out_col) = (0,0),(0,1),(1,0),(1,1).
  - frame_done one cycle after the last valid_out; busy low after it.
- Same frame with STRIDE=1 -> 9 valid_out pulses.
  - line_shift high exactly on pixels 4,9,14,19,24.
  - State is RUN from pixel 10.
- 5x5 STRIDE=2 with valid_in toggled 1/0 each cycle -> same 4 results.
  - Each valid_in_max[k] trails its hit by k+1 cycles; valid_out trails it by 4 cycles.
- Assert rst for one cycle after pixel 13 -> all outputs 0 next cycle, no frame_done.
  - A following full frame produces the normal 4 results.
- Pulse start mid-frame, and drive valid_in during DRAIN -> no state change, no extra line_wr_en.
  - With MAXPOOL_SCHED_ERR_EN: proto_err=1 and it stays high until the next accepted start.
- Drive valid_in in IDLE for 10 cycles without start -> line_wr_en=0, busy=0, no valid_out.

Source files
------------

// File: rtl/maxpool_window_sched_if.sv
// Frame-scheduler handshake bundle: start/pixel-valid in, line-buffer and max-tree controls out.
// proto_err exists only when MAXPOOL_SCHED_ERR_EN is defined.
interface maxpool_window_sched_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             valid_in;
    logic             line_wr_en;
    logic             line_shift;
    logic [2:0]       valid_in_max;
    logic             valid_out;
    logic [CNT_W-1:0] out_row;
    logic [CNT_W-1:0] out_col;
    logic             busy;
    logic             frame_done;
`ifdef MAXPOOL_SCHED_ERR_EN
    logic             proto_err;
`endif

    modport master (
`ifdef MAXPOOL_SCHED_ERR_EN
        input  proto_err,
`endif
        output start, valid_in,
        input  line_wr_en, line_shift, valid_in_max, valid_out,
        input  out_row, out_col, busy, frame_done
    );

    modport slave (
`ifdef MAXPOOL_SCHED_ERR_EN
        output proto_err,
`endif
        input  start, valid_in,
        output line_wr_en, line_shift, valid_in_max, valid_out,
        output out_row, out_col, busy, frame_done
    );
endinterface

// File: rtl/maxpool_window_sched.sv
// 3x3 max-pool frame scheduler; optional sticky proto_err under MAXPOOL_SCHED_ERR_EN.
// Window hit to valid_out is a fixed 4 cycles; no backpressure, upstream bubbles via valid_in.
module maxpool_window_sched #(
    parameter int WIDTH  = 5,
    parameter int HEIGHT = 5,
    parameter int STRIDE = 2,
    parameter int CNT_W  = 8
) (
    input logic                 clk,
    input logic                 rst,
    maxpool_window_sched_if.slave bus
);
    localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] OCOL_LAST = CNT_W'((WIDTH - 3) / STRIDE);
    localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [1:0]       PH_LAST   = 2'(STRIDE - 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] row, col, out_row, out_col;
    logic [1:0]       cph, rph, dcnt;
    logic [2:0]       vmax;
    logic             vout, busy, frame_done;
    logic             accept, row_end, hit;

    assign accept  = !rst && bus.valid_in && (state == S_FILL || state == S_RUN);
    assign row_end = accept && (col == COL_LAST);
    // Phase counters replace modulo: a window fires only when both phases are at zero.
    assign hit     = accept && (row >= TWO) && (col >= TWO) && (cph == 2'd0) && (rph == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            row        <= '0;
            col        <= '0;
            out_row    <= '0;
            out_col    <= '0;
            cph        <= 2'd0;
            rph        <= 2'd0;
            dcnt       <= 2'd0;
            vmax       <= 3'b000;
            vout       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vmax       <= {vmax[1:0], hit};
            vout       <= vmax[2];
            frame_done <= 1'b0;

            if (accept) begin
                if (row_end) begin
                    col <= '0;
                    row <= row + ONE;
                    cph <= 2'd0;
                    if (row >= TWO)
                        rph <= (rph == PH_LAST) ? 2'd0 : rph + 2'd1;
                end else begin
                    col <= col + ONE;
                    if (col >= TWO)
                        cph <= (cph == PH_LAST) ? 2'd0 : cph + 2'd1;
                end
            end

            if (vout) begin
                if (out_col == OCOL_LAST) begin
                    out_col <= '0;
                    out_row <= out_row + ONE;
                end else begin
                    out_col <= out_col + ONE;
                end
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state   <= S_FILL;
                        busy    <= 1'b1;
                        row     <= '0;
                        col     <= '0;
                        cph     <= 2'd0;
                        rph     <= 2'd0;
                        out_row <= '0;
                        out_col <= '0;
                    end
                end
                S_FILL: begin
                    if (row_end && row == ONE)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (row_end && row == ROW_LAST) begin
                        state <= S_DRAIN;
                        dcnt  <= 2'd0;
                    end
                end
                S_DRAIN: begin
                    // Four cycles lets the last hit reach valid_out before DONE.
                    dcnt <= dcnt + 2'd1;
                    if (dcnt == 2'd3) begin
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MAXPOOL_SCHED_ERR_EN
    logic proto_err;

    always_ff @(posedge clk) begin
        if (rst)
            proto_err <= 1'b0;
        else if (state == S_IDLE && bus.start)
            proto_err <= 1'b0;
        else if ((bus.start && busy) ||
                 (bus.valid_in && (state == S_DRAIN || state == S_DONE)))
            proto_err <= 1'b1;
    end

    assign bus.proto_err = proto_err;
`endif

    assign bus.line_wr_en   = accept;
    assign bus.line_shift   = row_end;
    assign bus.valid_in_max = vmax;
    assign bus.valid_out    = vout;
    assign bus.out_row      = out_row;
    assign bus.out_col      = out_col;
    assign bus.busy         = busy;
    assign bus.frame_done   = frame_done;
endmodule
